// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: memory-stage FSM states, datapath widths and the
// MEM/WB register bundle used by the memory and write-back stages.
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic                  memToReg;
    logic                  regWrite;
    logic [DATA_W-1:0]     readData;
    logic [DATA_W-1:0]     aluResult;
    logic [REG_ADDR_W-1:0] writeAddrReg;
  } memwb_t;

endpackage

// File: rtl/mw_buffer.sv
// MEM/WB pipeline register. Loads every cycle; a bubble clears the write-back
// controls and keeps the data fields, and read data only updates on request.
module mw_buffer #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bubble,
  input  logic                  rdata_load,
  input  logic                  next_mem_to_reg,
  input  logic                  next_reg_write,
  input  logic [DATA_W-1:0]     next_alu_result,
  input  logic [REG_ADDR_W-1:0] next_write_addr,
  input  logic [DATA_W-1:0]     next_read_data,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic [DATA_W-1:0]     read_data,
  output logic [DATA_W-1:0]     alu_result,
  output logic [REG_ADDR_W-1:0] write_addr
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_to_reg <= 1'b0;
      reg_write  <= 1'b0;
      read_data  <= '0;
      alu_result <= '0;
      write_addr <= '0;
    end else begin
      if (bubble) begin
        mem_to_reg <= 1'b0;
        reg_write  <= 1'b0;
      end else begin
        mem_to_reg <= next_mem_to_reg;
        reg_write  <= next_reg_write;
        alu_result <= next_alu_result;
        write_addr <= next_write_addr;
      end
      if (rdata_load) read_data <= next_read_data;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory pipeline stage: data-memory req/ack access, branch resolution and
// MEM/WB load. Optional ack timeout with sticky error under DMEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int DATA_W         = cpu_pkg::DATA_W,
  parameter int ADDR_W         = cpu_pkg::ADDR_W,
  parameter int REG_ADDR_W     = cpu_pkg::REG_ADDR_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  branch_i,
  input  logic                  memToRead_i,
  input  logic                  memToReg_i,
  input  logic                  memToWrite_i,
  input  logic                  regWrite_i,
  input  logic                  zf_i,
  input  logic [ADDR_W-1:0]     branchAddr_i,
  input  logic [DATA_W-1:0]     aluResult_i,
  input  logic [DATA_W-1:0]     rtData_i,
  input  logic [REG_ADDR_W-1:0] writeAddrReg_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_W-1:0]     dmem_addr_o,
  output logic [DATA_W-1:0]     dmem_wdata_o,
  input  logic                  dmem_ack_i,
  input  logic [DATA_W-1:0]     dmem_rdata_i,
  output logic                  stall_o,
  output logic                  pcSrc_o,
  output logic [ADDR_W-1:0]     branchAddr_o,
  output logic                  memToReg_o,
  output logic                  regWrite_o,
  output logic [DATA_W-1:0]     readData_o,
  output logic [DATA_W-1:0]     aluResult_o,
  output logic [REG_ADDR_W-1:0] writeAddrReg_o,
  output logic                  error_o
);

  import cpu_pkg::*;

  mem_state_e        state_q, state_d;
  logic              acc;
  logic              req_d, we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              bubble, rdata_load;
  logic              timeout;

  // A write wins when both read and write are decoded.
  assign acc          = memToRead_i | memToWrite_i;
  assign pcSrc_o      = branch_i & zf_i;
  assign branchAddr_o = branchAddr_i;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Fires in the BUSY cycle that would complete TIMEOUT_CYCLES waits without ack.
  assign timeout = (state_q == BUSY) & ~dmem_ack_i &
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE) cnt_q <= '0;
      else if (!dmem_ack_i) cnt_q <= cnt_q + CNT_W'(1);
      if (timeout) err_q <= 1'b1;
    end
  end

  assign error_o = err_q;
`else
  assign timeout = 1'b0;
  assign error_o = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    req_d      = dmem_req_o;
    we_d       = dmem_we_o;
    addr_d     = dmem_addr_o;
    wdata_d    = dmem_wdata_o;
    bubble     = 1'b1;
    rdata_load = 1'b0;
    stall_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = memToWrite_i;
          addr_d  = aluResult_i;
          wdata_d = rtData_i;
          stall_o = 1'b1;
        end else begin
          bubble = 1'b0;
        end
      end
      BUSY: begin
        // Upstream held the instruction, so its controls are still on the inputs.
        if (dmem_ack_i) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          bubble     = 1'b0;
          rdata_load = ~dmem_we_o;
        end else if (timeout) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else begin
          stall_o = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
    end else begin
      state_q      <= state_d;
      dmem_req_o   <= req_d;
      dmem_we_o    <= we_d;
      dmem_addr_o  <= addr_d;
      dmem_wdata_o <= wdata_d;
    end
  end

  mw_buffer #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_mw_buffer (
    .clk             (clk_i),
    .rst_n           (rst_ni),
    .bubble          (bubble),
    .rdata_load      (rdata_load),
    .next_mem_to_reg (memToReg_i),
    .next_reg_write  (regWrite_i),
    .next_alu_result (aluResult_i),
    .next_write_addr (writeAddrReg_i),
    .next_read_data  (dmem_rdata_i),
    .mem_to_reg      (memToReg_o),
    .reg_write       (regWrite_o),
    .read_data       (readData_o),
    .alu_result      (aluResult_o),
    .write_addr      (writeAddrReg_o)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a transaction-level model,
// with directed load/store/branch/reset (and timeout) scenarios.
module tb_mem_access_stage;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;
  localparam int TO = 4;
`ifdef DMEM_TIMEOUT_EN
  localparam int LATMAX = 5;
`else
  localparam int LATMAX = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          branch_i, memToRead_i, memToReg_i, memToWrite_i, regWrite_i, zf_i;
  logic [AW-1:0] branchAddr_i;
  logic [DW-1:0] aluResult_i, rtData_i;
  logic [RW-1:0] writeAddrReg_i;
  logic          dmem_req_o, dmem_we_o;
  logic [AW-1:0] dmem_addr_o;
  logic [DW-1:0] dmem_wdata_o;
  logic          dmem_ack_i;
  logic [DW-1:0] dmem_rdata_i;
  logic          stall_o, pcSrc_o;
  logic [AW-1:0] branchAddr_o;
  logic          memToReg_o, regWrite_o;
  logic [DW-1:0] readData_o, aluResult_o;
  logic [RW-1:0] writeAddrReg_o;
  logic          error_o;

  always #5 clk = ~clk;

  mem_access_stage #(
    .DATA_W(DW), .ADDR_W(AW), .REG_ADDR_W(RW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .branch_i(branch_i), .memToRead_i(memToRead_i), .memToReg_i(memToReg_i),
    .memToWrite_i(memToWrite_i), .regWrite_i(regWrite_i), .zf_i(zf_i),
    .branchAddr_i(branchAddr_i), .aluResult_i(aluResult_i), .rtData_i(rtData_i),
    .writeAddrReg_i(writeAddrReg_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall_o), .pcSrc_o(pcSrc_o), .branchAddr_o(branchAddr_o),
    .memToReg_o(memToReg_o), .regWrite_o(regWrite_o), .readData_o(readData_o),
    .aluResult_o(aluResult_o), .writeAddrReg_o(writeAddrReg_o), .error_o(error_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: one outstanding memory transaction plus the MEM/WB contents.
  bit            m_busy, m_req, m_we, m_mtr, m_rw, m_err, m_real;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd, m_alu;
  logic [RW-1:0] m_wa;
  int            m_bcyc;
  bit            n_busy, n_req, n_we, n_mtr, n_rw, n_err, n_real;
  logic [AW-1:0] n_addr;
  logic [DW-1:0] n_wdata, n_rd, n_alu;
  logic [RW-1:0] n_wa;
  int            n_bcyc;
  bit            exp_stall, last_stall;

  // Memory responder.
  int            ack_cnt;
  int            lat_next;
  bit            prev_req, spur_en;
  logic [DW-1:0] ack_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_timeout();
`ifdef DMEM_TIMEOUT_EN
    return m_busy && !dmem_ack_i && (m_bcyc == TO - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_busy = 0; m_req = 0; m_we = 0; m_mtr = 0; m_rw = 0; m_err = 0; m_real = 1;
    m_addr = '0; m_wdata = '0; m_rd = '0; m_alu = '0; m_wa = '0; m_bcyc = 0;
  endtask

  task automatic compare();
    bit acc;
    acc = memToRead_i | memToWrite_i;
    exp_stall = (!m_busy && acc) || (m_busy && !dmem_ack_i && !model_timeout());
    chk("stall", stall_o, exp_stall);
    chk("pcSrc", pcSrc_o, branch_i & zf_i);
    chk("branchAddr", branchAddr_o, branchAddr_i);
    chk("req", dmem_req_o, m_req);
    if (m_req) begin
      chk("we", dmem_we_o, m_we);
      chk("addr", dmem_addr_o, m_addr);
      chk("wdata", dmem_wdata_o, m_wdata);
    end
    chk("memToReg", memToReg_o, m_mtr);
    chk("regWrite", regWrite_o, m_rw);
    chk("readData", readData_o, m_rd);
    chk("error", error_o, m_err);
    if (m_real) begin
      chk("aluResult", aluResult_o, m_alu);
      chk("writeAddrReg", writeAddrReg_o, m_wa);
    end
  endtask

  task automatic model_step();
    bit acc;
    acc = memToRead_i | memToWrite_i;
    n_busy = m_busy; n_req = m_req; n_we = m_we; n_addr = m_addr; n_wdata = m_wdata;
    n_mtr = 0; n_rw = 0; n_rd = m_rd; n_alu = m_alu; n_wa = m_wa; n_err = m_err;
    n_real = m_real; n_bcyc = m_bcyc;
    if (!rst_ni) begin
      n_busy = 0; n_req = 0; n_we = 0; n_addr = '0; n_wdata = '0; n_rd = '0;
      n_alu = '0; n_wa = '0; n_err = 0; n_real = 1; n_bcyc = 0;
    end else if (!m_busy) begin
      if (acc) begin
        n_busy = 1; n_req = 1; n_we = memToWrite_i; n_addr = aluResult_i;
        n_wdata = rtData_i; n_bcyc = 0; n_real = 0;
      end else begin
        n_mtr = memToReg_i; n_rw = regWrite_i; n_alu = aluResult_i;
        n_wa = writeAddrReg_i; n_real = 1;
      end
    end else if (dmem_ack_i) begin
      n_busy = 0; n_req = 0;
      n_mtr = memToReg_i; n_rw = regWrite_i; n_alu = aluResult_i;
      n_wa = writeAddrReg_i; n_real = 1;
      if (!m_we) n_rd = dmem_rdata_i;
    end else if (model_timeout()) begin
      n_busy = 0; n_req = 0; n_err = 1;
    end else begin
      n_bcyc = m_bcyc + 1;
    end
  endtask

  task automatic respond();
    if (m_req) begin
      if (!prev_req) ack_cnt = lat_next;
      if (ack_cnt == 0) begin
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = ack_data;
      end else begin
        dmem_ack_i = 1'b0;
        ack_cnt--;
      end
    end else begin
      dmem_ack_i   = spur_en && ($urandom_range(0, 7) == 0);
      dmem_rdata_i = $urandom;
    end
    prev_req = m_req;
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    model_step();
    last_stall = exp_stall;
    @(posedge clk);
    #1;
    m_busy = n_busy; m_req = n_req; m_we = n_we; m_addr = n_addr; m_wdata = n_wdata;
    m_mtr = n_mtr; m_rw = n_rw; m_rd = n_rd; m_alu = n_alu; m_wa = n_wa;
    m_err = n_err; m_real = n_real; m_bcyc = n_bcyc;
    respond();
  endtask

  task automatic set_instr(input bit rd, input bit wr, input bit mtr, input bit rw,
                           input bit br, input bit zf, input logic [AW-1:0] baddr,
                           input logic [DW-1:0] alu, input logic [DW-1:0] rt,
                           input logic [RW-1:0] wa);
    memToRead_i = rd; memToWrite_i = wr; memToReg_i = mtr; regWrite_i = rw;
    branch_i = br; zf_i = zf; branchAddr_i = baddr; aluResult_i = alu;
    rtData_i = rt; writeAddrReg_i = wa;
  endtask

  task automatic nop();
    set_instr(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
  endtask

  task automatic rand_instr();
    int k;
    k = $urandom_range(0, 3);
    set_instr(0, 0, 0, 1'($urandom), 0, 1'($urandom), $urandom, $urandom,
              $urandom, 5'($urandom));
    case (k)
      1: begin
        memToRead_i = 1; memToReg_i = 1; regWrite_i = 1;
        memToWrite_i = ($urandom_range(0, 7) == 0);
      end
      2: begin memToWrite_i = 1; regWrite_i = 0; end
      3: begin branch_i = 1; regWrite_i = 0; end
      default: ;
    endcase
  endtask

  // Run until the access completes; returns req-high and regWrite-high cycle counts.
  task automatic run_access(input string name, output int req_cyc, output int rw_cyc);
    int guard;
    req_cyc = 0; rw_cyc = 0; guard = 0;
    do begin
      tick();
      if (dmem_req_o) req_cyc++;
      if (regWrite_o) rw_cyc++;
      guard++;
    end while (last_stall && guard < 200);
    if (guard >= 200) begin
      miscompares++;
      $display("FAIL %s: access did not complete within 200 cycles", name);
    end
  endtask

  initial begin
    int rq, rwc;
    rst_ni = 1'b0;
    nop();
    dmem_ack_i = 0; dmem_rdata_i = '0;
    spur_en = 0; lat_next = 0; ack_cnt = 0; prev_req = 0; ack_data = '0;
    last_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("reset_req", dmem_req_o, 0);
    chk("reset_regWrite", regWrite_o, 0);
    chk("reset_readData", readData_o, 0);
    chk("reset_error", error_o, 0);
    rst_ni = 1'b1;

    // ALU op
    set_instr(0, 0, 0, 1, 0, 0, '0, 32'h0000_00AA, '0, 5'd5);
    tick();
    chk("alu_regWrite", regWrite_o, 1);
    chk("alu_result", aluResult_o, 32'hAA);
    chk("alu_waddr", writeAddrReg_o, 5);
    nop();
    tick();

    // Load, ack on the third request cycle
    lat_next = 2; ack_data = 32'hDEAD_BEEF;
    set_instr(1, 0, 1, 1, 0, 0, '0, 32'h100, '0, 5'd7);
    tick();
    chk("load_addr", dmem_addr_o, 32'h100);
    chk("load_we", dmem_we_o, 0);
    run_access("load", rq, rwc);
    chk("load_req_cycles", rq + 1, 3);
    chk("load_readData", readData_o, 32'hDEAD_BEEF);
    chk("load_memToReg", memToReg_o, 1);
    nop();
    tick();
    chk("load_regWrite_pulses", rwc + (regWrite_o ? 1 : 0), 1);

    // Store, ack one cycle later
    lat_next = 1; ack_data = $urandom;
    set_instr(0, 1, 0, 0, 0, 0, '0, 32'h200, 32'h1234, 5'd3);
    tick();
    chk("store_we", dmem_we_o, 1);
    chk("store_wdata", dmem_wdata_o, 32'h1234);
    run_access("store", rq, rwc);
    chk("store_regWrite", rwc, 0);
    nop();
    tick();
    chk("store_idle_stall", stall_o, 0);

    // Branch resolution is combinational
    set_instr(0, 0, 0, 0, 1, 1, 32'h40, '0, '0, '0);
    #1;
    chk("branch_taken", pcSrc_o, 1);
    chk("branch_addr", branchAddr_o, 32'h40);
    zf_i = 0;
    #1;
    chk("branch_not_taken", pcSrc_o, 0);
    tick();

    // Reset while BUSY, then a late ack
    lat_next = 50;
    set_instr(1, 0, 1, 1, 0, 0, '0, 32'h300, '0, 5'd9);
    tick();
    tick();
    rst_ni = 1'b0;
    tick();
    chk("rstbusy_req", dmem_req_o, 0);
    chk("rstbusy_regWrite", regWrite_o, 0);
    chk("rstbusy_aluResult", aluResult_o, 0);
    rst_ni = 1'b1;
    nop();
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hBAD0_BAD0;
    tick();
    chk("late_ack_readData", readData_o, 0);
    lat_next = 0; ack_data = 32'h5555_AAAA;
    set_instr(1, 0, 1, 1, 0, 0, '0, 32'h44, '0, 5'd2);
    run_access("post_reset_load", rq, rwc);
    chk("post_reset_readData", readData_o, 32'h5555_AAAA);

`ifdef DMEM_TIMEOUT_EN
    lat_next = 100;
    set_instr(1, 0, 1, 1, 0, 0, '0, 32'h80, '0, 5'd4);
    run_access("timeout", rq, rwc);
    chk("timeout_req_cycles", rq, TO);
    chk("timeout_error", error_o, 1);
    nop();
    tick();
    chk("timeout_error_sticky", error_o, 1);
    chk("timeout_resume_stall", stall_o, 0);
`endif

    // Randomized traffic
    spur_en = 1;
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall) begin
        rand_instr();
        lat_next = $urandom_range(0, LATMAX);
      end
      ack_data = $urandom;
      rst_ni = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_ni = 1'b1;
    nop();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
